// File: rtl/instruction_decoder_pkg.sv
// Shared opcode prefixes, register-field enums and ALU function codes for the instruction decoder.
package instruction_decoder_pkg;

  localparam logic [0:0] OP_LOAD   = 1'b0;     // ir[7]
  localparam logic [1:0] OP_MOVE   = 2'b10;    // ir[7:6]
  localparam logic [2:0] OP_ALU    = 3'b110;   // ir[7:5]
  localparam logic [3:0] OP_JMP    = 4'b1110;  // ir[7:4]
  localparam logic [3:0] OP_JMP_NZ = 4'b1111;  // ir[7:4]
  localparam logic [7:0] NOP_INSTR = 8'h80;

  typedef enum logic [2:0] {
    DST_X0, DST_X1, DST_Y0, DST_Y1, DST_O_REG, DST_M, DST_I, DST_DM
  } dst_e;

  typedef enum logic [2:0] {
    SRC_X0, SRC_X1, SRC_Y0, SRC_Y1, SRC_R, SRC_M, SRC_I, SRC_DM
  } src_e;

  // Function meaning is owned by the ALU; the decoder only forwards the code.
  typedef enum logic [2:0] {
    ALU_FN0, ALU_FN1, ALU_FN2, ALU_FN3, ALU_FN4, ALU_FN5, ALU_FN6, ALU_FN7
  } alu_func_e;

endpackage

// File: rtl/zero_flag_reg.sv
// Zero flag register: loads d when load is high, clears on active-low synchronous reset.
module zero_flag_reg
  import instruction_decoder_pkg::*;
(
  input  logic clk,
  input  logic sync_reset_n,
  input  logic load,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_decoder.sv
// Registers the program-memory byte and decodes it one cycle later; squashes the slot after a taken jump.
// ILLEGAL_TRAP_EN adds a sticky illegal_op flag for self-moves other than x0,x0.
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                sync_reset_n,
  input  logic [7:0]          pm_data,
  input  logic                alu_zero,
  output logic                jmp,
  output logic                jmp_nz,
  output logic [3:0]          jmp_addr,
  output logic                dont_jmp,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [2:0]          src_sel,
  output logic                imm_sel,
  output logic [3:0]          imm,
  output logic                alu_en,
  output logic [2:0]          alu_func,
  output logic                x_sel,
  output logic                y_sel,
  output logic                illegal_op
);

  logic [7:0] ir;
  logic       ir_valid;
  logic       squash;
  logic       live;
  logic       taken;
  logic       z;
  dst_e       dst_fld;
  src_e       src_fld;
  alu_func_e  func_fld;

  always_ff @(posedge clk) begin
    ir <= pm_data;
    if (!sync_reset_n) begin
      ir_valid <= 1'b0;
      squash   <= 1'b0;
    end else begin
      ir_valid <= 1'b1;
      squash   <= taken;
    end
  end

  assign live = ir_valid && !squash;

  always_comb begin
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    jmp_addr = 4'h0;
    reg_en   = '0;
    src_sel  = 3'd0;
    imm_sel  = 1'b0;
    imm      = 4'h0;
    alu_en   = 1'b0;
    alu_func = 3'd0;
    x_sel    = 1'b0;
    y_sel    = 1'b0;
    dst_fld  = dst_e'(ir[6:4]);
    src_fld  = src_e'(ir[2:0]);
    func_fld = alu_func_e'(ir[2:0]);
    if (live) begin
      if (ir[7] == OP_LOAD) begin
        reg_en  = NUM_REGS'(1) << dst_fld;
        imm_sel = 1'b1;
        imm     = ir[3:0];
      end else if (ir[7:6] == OP_MOVE) begin
        dst_fld = dst_e'(ir[5:3]);
        // A move onto itself is a NOP: no enable, bus left idle.
        if (ir[5:3] != ir[2:0]) begin
          reg_en  = NUM_REGS'(1) << dst_fld;
          src_sel = src_fld;
        end
      end else if (ir[7:5] == OP_ALU) begin
        alu_en   = 1'b1;
        x_sel    = ir[4];
        y_sel    = ir[3];
        alu_func = func_fld;
      end else if (ir[7:4] == OP_JMP) begin
        jmp      = 1'b1;
        jmp_addr = ir[3:0];
      end else begin
        jmp_nz   = 1'b1;
        jmp_addr = ir[3:0];
      end
    end
  end

  zero_flag_reg u_zero_flag (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .load         (alu_en),
    .d            (alu_zero),
    .q            (z)
  );

  assign dont_jmp = z;
  assign taken    = jmp || (jmp_nz && !dont_jmp);

`ifdef ILLEGAL_TRAP_EN
  logic self_move;
  logic illegal;

  assign self_move = live && (ir[7:6] == OP_MOVE) && (ir[5:3] == ir[2:0])
                     && (ir[5:3] != DST_X0);

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      illegal <= 1'b0;
    end else if (self_move) begin
      illegal <= 1'b1;
    end
  end

  assign illegal_op = illegal;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: expectations queued when a byte is driven, compared when decoded.
module tb_instruction_decoder;

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sync_reset_n;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic       jmp, jmp_nz, dont_jmp, imm_sel, alu_en, x_sel, y_sel, illegal_op;
  logic [3:0] jmp_addr, imm;
  logic [7:0] reg_en;
  logic [2:0] src_sel, alu_func;

  typedef struct packed {
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [7:0] reg_en;
    logic [2:0] src_sel;
    logic       imm_sel;
    logic [3:0] imm;
    logic       alu_en;
    logic [2:0] alu_func;
    logic       x_sel;
    logic       y_sel;
    logic       illegal_op;
  } obs_t;

  typedef struct {
    logic [7:0] b;
    obs_t       e;
  } vec_t;

  obs_t  sb[$];
  string sb_name[$];
  int    checks = 0;
  int    passes = 0;

  instruction_decoder dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .pm_data      (pm_data),
    .alu_zero     (alu_zero),
    .jmp          (jmp),
    .jmp_nz       (jmp_nz),
    .jmp_addr     (jmp_addr),
    .dont_jmp     (dont_jmp),
    .reg_en       (reg_en),
    .src_sel      (src_sel),
    .imm_sel      (imm_sel),
    .imm          (imm),
    .alu_en       (alu_en),
    .alu_func     (alu_func),
    .x_sel        (x_sel),
    .y_sel        (y_sel),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{jmp, jmp_nz, jmp_addr, dont_jmp, reg_en, src_sel, imm_sel, imm,
             alu_en, alu_func, x_sel, y_sel, illegal_op};
  endfunction

  function automatic obs_t e_zero(logic dj, logic ill);
    obs_t e = '0;
    e.dont_jmp = dj; e.illegal_op = ill;
    return e;
  endfunction

  function automatic obs_t e_load(logic [7:0] en, logic [3:0] im, logic dj, logic ill);
    obs_t e = e_zero(dj, ill);
    e.reg_en = en; e.imm_sel = 1'b1; e.imm = im;
    return e;
  endfunction

  function automatic obs_t e_move(logic [7:0] en, logic [2:0] src, logic dj, logic ill);
    obs_t e = e_zero(dj, ill);
    e.reg_en = en; e.src_sel = src;
    return e;
  endfunction

  function automatic obs_t e_alu(logic x, logic y, logic [2:0] f, logic dj, logic ill);
    obs_t e = e_zero(dj, ill);
    e.alu_en = 1'b1; e.x_sel = x; e.y_sel = y; e.alu_func = f;
    return e;
  endfunction

  function automatic obs_t e_jmp(logic nz, logic [3:0] a, logic dj, logic ill);
    obs_t e = e_zero(dj, ill);
    e.jmp = !nz; e.jmp_nz = nz; e.jmp_addr = a;
    return e;
  endfunction

  function automatic vec_t v(logic [7:0] b, obs_t e);
    vec_t r;
    r.b = b; r.e = e;
    return r;
  endfunction

  task automatic test_reset();
    sync_reset_n = 1'b0;
    pm_data      = 8'hE5;
    alu_zero     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sample() !== e_zero(1'b0, 1'b0))
        $display("FAIL reset_cycle%0d: got %h expected %h", i, sample(), e_zero(1'b0, 1'b0));
      else passes++;
    end
    @(posedge clk); #1;
    sync_reset_n = 1'b1;
    pm_data      = 8'h3A;
    sb.push_back(e_load(8'h08, 4'hA, 1'b0, 1'b0));
    sb_name.push_back("load_3A");
    @(negedge clk);
    checks++;
    if (sample() !== e_zero(1'b0, 1'b0))
      $display("FAIL release_cycle: got %h expected %h", sample(), e_zero(1'b0, 1'b0));
    else passes++;
  endtask

  task automatic test_load_move();
    vec_t vs[$];
    obs_t got, exp;
    string nm;
    alu_zero = 1'b0;
    vs.push_back(v(8'hA1, e_move(8'h10, 3'd1, 1'b0, 1'b0)));
    vs.push_back(v(8'h7F, e_load(8'h80, 4'hF, 1'b0, 1'b0)));
    vs.push_back(v(8'h80, e_zero(1'b0, 1'b0)));
    vs.push_back(v(8'h8E, e_move(8'h02, 3'd6, 1'b0, 1'b0)));
    vs.push_back(v(8'h5C, e_load(8'h20, 4'hC, 1'b0, 1'b0)));
    for (int i = 0; i <= vs.size(); i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp = sb.pop_front(); nm = sb_name.pop_front(); got = sample();
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else passes++;
      end
      if (i < vs.size()) begin
        pm_data = vs[i].b;
        sb.push_back(vs[i].e); sb_name.push_back($sformatf("loadmove_%h", vs[i].b));
      end else pm_data = 8'h80;
    end
  endtask

  task automatic test_alu_zero();
    vec_t vs[$];
    obs_t got, exp;
    string nm;
    alu_zero = 1'b1;
    vs.push_back(v(8'hD3, e_alu(1'b1, 1'b0, 3'd3, 1'b0, 1'b0)));
    vs.push_back(v(8'h00, e_load(8'h01, 4'h0, 1'b1, 1'b0)));
    vs.push_back(v(8'hF7, e_jmp(1'b1, 4'h7, 1'b1, 1'b0)));
    vs.push_back(v(8'h3A, e_load(8'h08, 4'hA, 1'b1, 1'b0)));
    for (int i = 0; i <= vs.size(); i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp = sb.pop_front(); nm = sb_name.pop_front(); got = sample();
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else passes++;
      end
      if (i < vs.size()) begin
        pm_data = vs[i].b;
        sb.push_back(vs[i].e); sb_name.push_back($sformatf("alu_z1_%h", vs[i].b));
      end else pm_data = 8'h80;
    end
  endtask

  task automatic test_jump_nz();
    vec_t vs[$];
    obs_t got, exp;
    string nm;
    alu_zero = 1'b0;
    vs.push_back(v(8'hCC, e_alu(1'b0, 1'b1, 3'd4, 1'b1, 1'b0)));
    vs.push_back(v(8'h11, e_load(8'h02, 4'h1, 1'b0, 1'b0)));
    vs.push_back(v(8'hF7, e_jmp(1'b1, 4'h7, 1'b0, 1'b0)));
    vs.push_back(v(8'h25, e_zero(1'b0, 1'b0)));
    vs.push_back(v(8'h42, e_load(8'h10, 4'h2, 1'b0, 1'b0)));
    for (int i = 0; i <= vs.size(); i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp = sb.pop_front(); nm = sb_name.pop_front(); got = sample();
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else passes++;
      end
      if (i < vs.size()) begin
        pm_data = vs[i].b;
        sb.push_back(vs[i].e); sb_name.push_back($sformatf("jnz_taken_%h", vs[i].b));
      end else pm_data = 8'h80;
    end
  endtask

  task automatic test_back_to_back();
    vec_t vs[$];
    obs_t got, exp;
    string nm;
    alu_zero = 1'b0;
    vs.push_back(v(8'hE2, e_jmp(1'b0, 4'h2, 1'b0, 1'b0)));
    vs.push_back(v(8'h15, e_zero(1'b0, 1'b0)));
    vs.push_back(v(8'h5C, e_load(8'h20, 4'hC, 1'b0, 1'b0)));
    vs.push_back(v(8'hE3, e_jmp(1'b0, 4'h3, 1'b0, 1'b0)));
    vs.push_back(v(8'hF4, e_zero(1'b0, 1'b0)));
    vs.push_back(v(8'h60, e_load(8'h40, 4'h0, 1'b0, 1'b0)));
    for (int i = 0; i <= vs.size(); i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp = sb.pop_front(); nm = sb_name.pop_front(); got = sample();
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else passes++;
      end
      if (i < vs.size()) begin
        pm_data = vs[i].b;
        sb.push_back(vs[i].e); sb_name.push_back($sformatf("b2b_%h", vs[i].b));
      end else pm_data = 8'h80;
    end
  endtask

  task automatic test_illegal();
    vec_t vs[$];
    obs_t got, exp;
    string nm;
    alu_zero = 1'b0;
    vs.push_back(v(8'h9B, e_zero(1'b0, 1'b0)));
    vs.push_back(v(8'h80, e_zero(1'b0, TRAP)));
    vs.push_back(v(8'h12, e_load(8'h02, 4'h2, 1'b0, TRAP)));
    vs.push_back(v(8'h80, e_zero(1'b0, TRAP)));
    for (int i = 0; i <= vs.size(); i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp = sb.pop_front(); nm = sb_name.pop_front(); got = sample();
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else passes++;
      end
      if (i < vs.size()) begin
        pm_data = vs[i].b;
        sb.push_back(vs[i].e); sb_name.push_back($sformatf("illegal_%h", vs[i].b));
      end else pm_data = 8'h80;
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    alu_zero = 1'b0;
    @(negedge clk);
    pm_data = 8'hE1;
    @(negedge clk);
    got = sample(); exp = e_jmp(1'b0, 4'h1, 1'b0, TRAP);
    checks++;
    if (got !== exp) $display("FAIL mid_jmp_E1: got %h expected %h", got, exp);
    else passes++;
    sync_reset_n = 1'b0;
    pm_data      = 8'h21;
    @(negedge clk);
    got = sample(); exp = e_zero(1'b0, 1'b0);
    checks++;
    if (got !== exp) $display("FAIL mid_reset: got %h expected %h", got, exp);
    else passes++;
    @(posedge clk); #1;
    sync_reset_n = 1'b1;
    pm_data      = 8'h22;
    @(negedge clk);
    got = sample();
    checks++;
    if (got !== exp) $display("FAIL mid_release_cycle: got %h expected %h", got, exp);
    else passes++;
    @(negedge clk);
    got = sample(); exp = e_load(8'h04, 4'h2, 1'b0, 1'b0);
    checks++;
    if (got !== exp) $display("FAIL mid_resume_22: got %h expected %h", got, exp);
    else passes++;
    pm_data = 8'h80;
  endtask

  initial begin
    test_reset();
    test_load_move();
    test_alu_zero();
    test_jump_nz();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
